// File: rtl/frame_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : frame_serializer                                           |
// | Description : Parallel-to-serial framer: start bit, data bits, optional  |
// |               even parity (FRAME_SERIALIZER_PARITY_EN), stop bits.       |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module frame_serializer #(
    parameter int DATA_W    = 12,
    parameter int CLK_DIV   = 16,
    parameter int STOP_BITS = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic              sysclk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              serial_out,
    output logic              busy,
    output logic              frame_done
);

    localparam int c_BIT_W = $clog2(DATA_W + 1);
    localparam int c_DIV_W = 8;

    localparam logic [c_DIV_W-1:0] c_DIV_LAST    = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_PRELAST = c_DIV_W'(CLK_DIV - 2);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST    = c_BIT_W'(DATA_W - 1);
    localparam logic [c_BIT_W-1:0] c_STOP_LAST   = c_BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t              r_state_q,  w_state_d;
    logic [c_DIV_W-1:0]  r_div_q,    w_div_d;
    logic [c_BIT_W-1:0]  r_bit_q,    w_bit_d;
    logic [DATA_W-1:0]   r_shift_q,  w_shift_d;
    logic                r_serial_q, w_serial_d;
    logic                r_busy_q,   w_busy_d;
    logic                r_ready_q,  w_ready_d;
    logic                r_done_q,   w_done_d;
`ifdef FRAME_SERIALIZER_PARITY_EN
    logic                r_parity_q, w_parity_d;
`endif

    logic                w_accept;
    logic                w_bit_end;
    logic                w_load;
    logic                w_out_bit;
    logic [DATA_W-1:0]   w_shift_next;

    assign w_accept  = tx_valid & r_ready_q;
    assign w_bit_end = (r_div_q == c_DIV_LAST);

    // The outgoing bit always sits at the same end of the register; shifting
    // after each emitted bit brings the next one into place.
    assign w_out_bit    = (MSB_FIRST != 0) ? r_shift_q[DATA_W-1] : r_shift_q[0];
    assign w_shift_next = (MSB_FIRST != 0) ? {r_shift_q[DATA_W-2:0], 1'b0}
                                           : {1'b0, r_shift_q[DATA_W-1:1]};

    always_comb begin
        w_state_d  = r_state_q;
        w_div_d    = w_bit_end ? '0 : r_div_q + c_DIV_W'(1);
        w_bit_d    = r_bit_q;
        w_shift_d  = r_shift_q;
        w_serial_d = r_serial_q;
        w_busy_d   = r_busy_q;
        w_ready_d  = 1'b0;
        w_done_d   = 1'b0;
        w_load     = 1'b0;
`ifdef FRAME_SERIALIZER_PARITY_EN
        w_parity_d = r_parity_q;
`endif
        case (r_state_q)
            S_IDLE: begin
                w_div_d    = '0;
                w_serial_d = 1'b1;
                w_busy_d   = 1'b0;
                w_ready_d  = 1'b1;
                w_load     = w_accept;
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_d  = S_DATA;
                    w_bit_d    = '0;
                    w_serial_d = w_out_bit;
                    w_shift_d  = w_shift_next;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (r_bit_q == c_BIT_LAST) begin
`ifdef FRAME_SERIALIZER_PARITY_EN
                        w_state_d  = S_PARITY;
                        w_serial_d = r_parity_q;
`else
                        w_state_d  = S_STOP;
                        w_serial_d = 1'b1;
                        w_bit_d    = '0;
`endif
                    end else begin
                        w_bit_d    = r_bit_q + c_BIT_W'(1);
                        w_serial_d = w_out_bit;
                        w_shift_d  = w_shift_next;
                    end
                end
            end
`ifdef FRAME_SERIALIZER_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_d  = S_STOP;
                    w_serial_d = 1'b1;
                    w_bit_d    = '0;
                end
            end
`endif
            S_STOP: begin
                // Outputs are registered, so the final-cycle flags are armed one cycle early.
                if ((r_bit_q == c_STOP_LAST) && (r_div_q == c_DIV_PRELAST)) begin
                    w_ready_d = 1'b1;
                    w_done_d  = 1'b1;
                end
                if (w_bit_end) begin
                    if (r_bit_q == c_STOP_LAST) begin
                        w_state_d  = S_IDLE;
                        w_div_d    = '0;
                        w_bit_d    = '0;
                        w_serial_d = 1'b1;
                        w_busy_d   = 1'b0;
                        w_ready_d  = 1'b1;
                        w_load     = w_accept;
                    end else begin
                        w_bit_d = r_bit_q + c_BIT_W'(1);
                    end
                end
            end
            default: begin
                w_state_d  = S_IDLE;
                w_div_d    = '0;
                w_bit_d    = '0;
                w_serial_d = 1'b1;
                w_busy_d   = 1'b0;
                w_ready_d  = 1'b1;
            end
        endcase

        if (w_load) begin
            w_state_d  = S_START;
            w_div_d    = '0;
            w_bit_d    = '0;
            w_shift_d  = tx_data;
            w_serial_d = 1'b0;
            w_busy_d   = 1'b1;
            w_ready_d  = 1'b0;
`ifdef FRAME_SERIALIZER_PARITY_EN
            w_parity_d = ^tx_data;
`endif
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_state_q  <= S_IDLE;
            r_div_q    <= '0;
            r_bit_q    <= '0;
            r_shift_q  <= '0;
            r_serial_q <= 1'b1;
            r_busy_q   <= 1'b0;
            r_ready_q  <= 1'b1;
            r_done_q   <= 1'b0;
`ifdef FRAME_SERIALIZER_PARITY_EN
            r_parity_q <= 1'b0;
`endif
        end else begin
            r_state_q  <= w_state_d;
            r_div_q    <= w_div_d;
            r_bit_q    <= w_bit_d;
            r_shift_q  <= w_shift_d;
            r_serial_q <= w_serial_d;
            r_busy_q   <= w_busy_d;
            r_ready_q  <= w_ready_d;
            r_done_q   <= w_done_d;
`ifdef FRAME_SERIALIZER_PARITY_EN
            r_parity_q <= w_parity_d;
`endif
        end
    end

    assign tx_ready   = r_ready_q;
    assign serial_out = r_serial_q;
    assign busy       = r_busy_q;
    assign frame_done = r_done_q;

endmodule
`default_nettype wire
